// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 text-mode raster generator.
`timescale 1ns/1ps
package vga_pkg;

   // Default 640x480@60 timing, 25 MHz pixel clock.
   localparam int DEFAULT_H_VISIBLE  = 640;
   localparam int DEFAULT_H_FRONT    = 16;
   localparam int DEFAULT_H_SYNC     = 96;
   localparam int DEFAULT_H_BACK     = 48;
   localparam int DEFAULT_V_VISIBLE  = 480;
   localparam int DEFAULT_V_FRONT    = 10;
   localparam int DEFAULT_V_SYNC     = 2;
   localparam int DEFAULT_V_BACK     = 33;
   localparam int DEFAULT_CHAR_H     = 12;
   localparam int DEFAULT_PIPE_DELAY = 2;

   // Derived totals and sync windows for the default timing.
   localparam int H_TOTAL = DEFAULT_H_VISIBLE + DEFAULT_H_FRONT + DEFAULT_H_SYNC + DEFAULT_H_BACK;
   localparam int V_TOTAL = DEFAULT_V_VISIBLE + DEFAULT_V_FRONT + DEFAULT_V_SYNC + DEFAULT_V_BACK;
   localparam int H_SYNC_START = DEFAULT_H_VISIBLE + DEFAULT_H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + DEFAULT_H_SYNC - 1;
   localparam int V_SYNC_START = DEFAULT_V_VISIBLE + DEFAULT_V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + DEFAULT_V_SYNC - 1;

   // Glyphs are always 8 pixels wide, so the character column is a bit slice.
   localparam int GLYPH_W = 8;

   // Flags carried through the output delay line.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_flags_t;

   // Idle value: both syncs inactive (high), video blanked.
   localparam logic [2:0] FLAGS_IDLE = 3'b110;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position and sync bundle driven by the timing generator.
`timescale 1ns/1ps
interface vga_timing_gen_if;
   logic [9:0] HorizontalCounter;
   logic [9:0] VerticalCounter;
   logic [6:0] char_col;
   logic [5:0] char_row;
   logic [3:0] glyph_line;
   logic       line_start;
   logic       frame_start;
   logic       hsync;
   logic       vsync;
   logic       video_on;

   modport master (
      output HorizontalCounter, VerticalCounter, char_col, char_row, glyph_line,
             line_start, frame_start, hsync, vsync, video_on
   );

   modport slave (
      input HorizontalCounter, VerticalCounter, char_col, char_row, glyph_line,
            line_start, frame_start, hsync, vsync, video_on
   );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register that aligns sync/blank flags with the pixel stage.
`timescale 1ns/1ps
module sync_delay #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift the flags one stage per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every stage is reset so the outputs stay inactive until real flags have propagated through the whole chain.
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value in the same edge.
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, text-grid position and delayed sync/blank flags for the text display.
`timescale 1ns/1ps
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE  = DEFAULT_H_VISIBLE,
   parameter int H_FRONT    = DEFAULT_H_FRONT,
   parameter int H_SYNC     = DEFAULT_H_SYNC,
   parameter int H_BACK     = DEFAULT_H_BACK,
   parameter int V_VISIBLE  = DEFAULT_V_VISIBLE,
   parameter int V_FRONT    = DEFAULT_V_FRONT,
   parameter int V_SYNC     = DEFAULT_V_SYNC,
   parameter int V_BACK     = DEFAULT_V_BACK,
   parameter int CHAR_H     = DEFAULT_CHAR_H,
   parameter int PIPE_DELAY = DEFAULT_PIPE_DELAY
) (
   input  logic             clock25,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [3:0] GLYPH_LAST = 4'(CHAR_H - 1);

   // run_q is low for the first edge after reset so that edge presents 0,0 with both pulses.
   logic        run_q;
   logic [9:0]  h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic [5:0]  row_q, row_d;
   logic [3:0]  glyph_q, glyph_d;
   logic        line_start_q;
   logic        frame_start_q;
   sync_flags_t raw_flags;
   sync_flags_t dly_flags;

   // Next raster and text-grid position; the grid steps with the line counter, no divider.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      h_d     = h_q;
      v_d     = v_q;
      row_d   = row_q;
      glyph_d = glyph_q;
      if (run_q) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               // The last row is partial, so the wrap forces the grid back to 0.
               v_d     = '0;
               row_d   = '0;
               glyph_d = '0;
            end else begin
               v_d = v_q + 10'd1;
               if (glyph_q == GLYPH_LAST) begin
                  glyph_d = '0;
                  row_d   = row_q + 6'd1;
               end else begin
                  glyph_d = glyph_q + 4'd1;
               end
            end
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   // Register position, grid and pulses together so they stay mutually consistent.
   always_ff @(posedge clock25 or negedge reset_n) begin
      if (!reset_n) begin
         run_q         <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         row_q         <= '0;
         glyph_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         run_q         <= 1'b1;
         h_q           <= h_d;
         v_q           <= v_d;
         row_q         <= row_d;
         glyph_q       <= glyph_d;
         line_start_q  <= (h_d == '0);
         frame_start_q <= (h_d == '0) && (v_d == '0);
      end
   end

   // Decode undelayed sync/blank flags from the current position; idle until counting starts.
   always_comb begin
      raw_flags = FLAGS_IDLE;
      if (run_q) begin
         raw_flags.hsync    = !((h_q >= HS_START) && (h_q <= HS_END));
         raw_flags.vsync    = !((v_q >= VS_START) && (v_q <= VS_END));
         raw_flags.video_on = (h_q < H_VIS) && (v_q < V_VIS);
      end
   end

   sync_delay #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DELAY),
      .RST_VAL (FLAGS_IDLE)
   ) u_sync_delay (
      .clk   (clock25),
      .rst_n (reset_n),
      .d_i   (raw_flags),
      .q_o   (dly_flags)
   );

   assign vga.HorizontalCounter = h_q;
   assign vga.VerticalCounter   = v_q;
   assign vga.char_col          = h_q[9:$clog2(GLYPH_W)];
   assign vga.char_row          = row_q;
   assign vga.glyph_line        = glyph_q;
   assign vga.line_start        = line_start_q;
   assign vga.frame_start       = frame_start_q;
   assign vga.hsync             = dly_flags.hsync;
   assign vga.vsync             = dly_flags.vsync;
   assign vga.video_on          = dly_flags.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-timing instances at PIPE_DELAY 1/2/4 plus a narrow-line instance for frame-level checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic [6:0] col;
      logic [5:0] row;
      logic [3:0] gl;
      logic       ls;
      logic       fs;
      logic       hs;
      logic       vs;
      logic       vo;
   } vals_t;

   typedef struct {
      int    cyc;
      vals_t v;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   // Cycle index since reset release: 0 is the first cycle after the first rising edge.
   int cyc_a = -1;
   int cyc_s = -1;

   vec_t q_a[$];
   vec_t q_s[$];

   // Line-0 measurements for the PIPE_DELAY 1/2/4 instances.
   int fall[3]     = '{-1, -1, -1};
   int rise[3]     = '{-1, -1, -1};
   int vo_first[3] = '{-1, -1, -1};

   // Frame-level measurements on the narrow instance.
   int fs_cyc[4] = '{-1, -1, -1, -1};
   int fs_n      = 0;
   int win_vs    = 0;
   int win_vo    = 0;
   int win_hs    = 0;
   bit mid_done  = 1'b0;

   vga_timing_gen_if if_1 ();
   vga_timing_gen_if if_2 ();
   vga_timing_gen_if if_4 ();
   vga_timing_gen_if if_s ();

   vga_timing_gen #(.PIPE_DELAY(1)) u_dut1 (.clock25(clk), .reset_n(rst_a), .vga(if_1));
   vga_timing_gen #(.PIPE_DELAY(2)) u_dut2 (.clock25(clk), .reset_n(rst_a), .vga(if_2));
   vga_timing_gen #(.PIPE_DELAY(4)) u_dut4 (.clock25(clk), .reset_n(rst_a), .vga(if_4));
   // 24-cycle lines (16 visible, sync 18..21) with full vertical timing: frame = 12600 cycles.
   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2), .PIPE_DELAY(2)
   ) u_small (.clock25(clk), .reset_n(rst_b), .vga(if_s));

   always #20 clk = ~clk;

   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) cyc_a <= -1;
      else        cyc_a <= cyc_a + 1;
   end

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) cyc_s <= -1;
      else        cyc_s <= cyc_s + 1;
   end

   task automatic check(input string what, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", what, actual, expected);
      end
   endtask

   task automatic compare(input string tag, input int cyc, input vals_t act, input vals_t exp);
      string p;
      p = $sformatf("%s cyc=%0d", tag, cyc);
      check({p, " H"},           32'(act.h),   32'(exp.h));
      check({p, " V"},           32'(act.v),   32'(exp.v));
      check({p, " char_col"},    32'(act.col), 32'(exp.col));
      check({p, " char_row"},    32'(act.row), 32'(exp.row));
      check({p, " glyph_line"},  32'(act.gl),  32'(exp.gl));
      check({p, " line_start"},  32'(act.ls),  32'(exp.ls));
      check({p, " frame_start"}, 32'(act.fs),  32'(exp.fs));
      check({p, " hsync"},       32'(act.hs),  32'(exp.hs));
      check({p, " vsync"},       32'(act.vs),  32'(exp.vs));
      check({p, " video_on"},    32'(act.vo),  32'(exp.vo));
   endtask

   function automatic vals_t mk(input int h, input int v, input int col, input int row, input int gl,
                                input bit ls, input bit fs, input bit hs, input bit vs, input bit vo);
      vals_t r;
      r.h = 10'(h); r.v = 10'(v); r.col = 7'(col); r.row = 6'(row); r.gl = 4'(gl);
      r.ls = ls; r.fs = fs; r.hs = hs; r.vs = vs; r.vo = vo;
      return r;
   endfunction

   task automatic push(input bit to_small, input int cyc, input vals_t v);
      vec_t e;
      e.cyc = cyc;
      e.v   = v;
      if (to_small) q_s.push_back(e);
      else          q_a.push_back(e);
   endtask

   function automatic vals_t sample_a();
      vals_t r;
      r.h = if_2.HorizontalCounter; r.v = if_2.VerticalCounter; r.col = if_2.char_col;
      r.row = if_2.char_row; r.gl = if_2.glyph_line; r.ls = if_2.line_start;
      r.fs = if_2.frame_start; r.hs = if_2.hsync; r.vs = if_2.vsync; r.vo = if_2.video_on;
      return r;
   endfunction

   function automatic vals_t sample_s();
      vals_t r;
      r.h = if_s.HorizontalCounter; r.v = if_s.VerticalCounter; r.col = if_s.char_col;
      r.row = if_s.char_row; r.gl = if_s.glyph_line; r.ls = if_s.line_start;
      r.fs = if_s.frame_start; r.hs = if_s.hsync; r.vs = if_s.vsync; r.vo = if_s.video_on;
      return r;
   endfunction

   task automatic track(input int idx, input logic hs, input logic vo);
      if (cyc_a >= 0 && cyc_a < 800) begin
         if (vo_first[idx] < 0 && vo === 1'b1) vo_first[idx] = cyc_a;
         if (fall[idx] < 0 && hs === 1'b0) fall[idx] = cyc_a;
         else if (fall[idx] >= 0 && rise[idx] < 0 && hs === 1'b1) rise[idx] = cyc_a;
      end
   endtask

   // Monitor: sample on the falling edge, pop due vectors, gather measurements.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         if (rst_a === 1'b1 && cyc_a >= 0) begin
            while (q_a.size() > 0 && q_a[0].cyc == cyc_a) begin
               e = q_a.pop_front();
               compare("full", cyc_a, sample_a(), e.v);
            end
            track(0, if_1.hsync, if_1.video_on);
            track(1, if_2.hsync, if_2.video_on);
            track(2, if_4.hsync, if_4.video_on);
         end
         if (rst_b === 1'b1 && cyc_s >= 0) begin
            while (q_s.size() > 0 && q_s[0].cyc == cyc_s) begin
               e = q_s.pop_front();
               compare("narrow", cyc_s, sample_s(), e.v);
            end
            if (!mid_done) begin
               if (if_s.frame_start === 1'b1) begin
                  if (fs_n < 4) fs_cyc[fs_n] = cyc_s;
                  fs_n++;
               end
               if (cyc_s >= 12600 && cyc_s < 25200) begin
                  if (if_s.vsync === 1'b0)    win_vs++;
                  if (if_s.video_on === 1'b1) win_vo++;
                  if (if_s.hsync === 1'b0)    win_hs++;
               end
            end
         end
      end
   end

   // Stimulus: reset, directed expectations, mid-frame reset, final measurements.
   initial begin
      bit found;
      #5;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);

      compare("reset full", -1, sample_a(), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      compare("reset narrow", -1, sample_s(), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

      // Full-timing instance, PIPE_DELAY 2.
      push(0, 0,    mk(0,   0,  0,  0, 0,  1, 1, 1, 1, 0));
      push(0, 1,    mk(1,   0,  0,  0, 0,  0, 0, 1, 1, 0));
      push(0, 2,    mk(2,   0,  0,  0, 0,  0, 0, 1, 1, 1));
      push(0, 639,  mk(639, 0,  79, 0, 0,  0, 0, 1, 1, 1));
      push(0, 641,  mk(641, 0,  80, 0, 0,  0, 0, 1, 1, 1));
      push(0, 642,  mk(642, 0,  80, 0, 0,  0, 0, 1, 1, 0));
      push(0, 657,  mk(657, 0,  82, 0, 0,  0, 0, 1, 1, 0));
      push(0, 658,  mk(658, 0,  82, 0, 0,  0, 0, 0, 1, 0));
      push(0, 753,  mk(753, 0,  94, 0, 0,  0, 0, 0, 1, 0));
      push(0, 754,  mk(754, 0,  94, 0, 0,  0, 0, 1, 1, 0));
      push(0, 799,  mk(799, 0,  99, 0, 0,  0, 0, 1, 1, 0));
      push(0, 800,  mk(0,   1,  0,  0, 1,  1, 0, 1, 1, 0));
      push(0, 802,  mk(2,   1,  0,  0, 1,  0, 0, 1, 1, 1));
      push(0, 8800, mk(0,   11, 0,  0, 11, 1, 0, 1, 1, 0));
      push(0, 9600, mk(0,   12, 0,  1, 0,  1, 0, 1, 1, 0));
      push(0, 9610, mk(10,  12, 1,  1, 0,  0, 0, 1, 1, 1));

      // Narrow instance: grid rows near the bottom, vsync window, frame wrap.
      push(1, 11496, mk(0,  479, 0, 39, 11, 1, 0, 1, 1, 0));
      push(1, 11520, mk(0,  480, 0, 40, 0,  1, 0, 1, 1, 0));
      push(1, 11522, mk(2,  480, 0, 40, 0,  0, 0, 1, 1, 0));
      push(1, 11760, mk(0,  490, 0, 40, 10, 1, 0, 1, 1, 0));
      push(1, 11762, mk(2,  490, 0, 40, 10, 0, 0, 1, 0, 0));
      push(1, 11810, mk(2,  492, 0, 41, 0,  0, 0, 1, 1, 0));
      push(1, 12576, mk(0,  524, 0, 43, 8,  1, 0, 1, 1, 0));
      push(1, 12599, mk(23, 524, 2, 43, 8,  0, 0, 0, 1, 0));
      push(1, 12600, mk(0,  0,   0, 0,  0,  1, 1, 1, 1, 0));
      push(1, 12602, mk(2,  0,   0, 0,  0,  0, 0, 1, 1, 1));

      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (25300) @(negedge clk);

      // Mid-frame reset on the narrow instance at H=10, V=200.
      found = 1'b0;
      for (int i = 0; i < 30000 && !found; i++) begin
         @(negedge clk);
         if (if_s.HorizontalCounter == 10'd10 && if_s.VerticalCounter == 10'd200) found = 1'b1;
      end
      check("midframe position reached", 32'(found), 32'd1);
      check("midframe video_on before reset", 32'(if_s.video_on), 32'd1);
      mid_done = 1'b1;
      #5;
      rst_b = 1'b0;
      #1;
      compare("async reset", -1, sample_s(), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      repeat (3) @(negedge clk);
      compare("held in reset", -1, sample_s(), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      push(1, 0, mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
      push(1, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      push(1, 2, mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      rst_b = 1'b1;
      repeat (10) @(negedge clk);

      // Delay sweep: hsync edge offset and width, first visible cycle.
      check("hsync fall pd1", 32'(fall[0]), 32'd657);
      check("hsync fall pd2", 32'(fall[1]), 32'd658);
      check("hsync fall pd4", 32'(fall[2]), 32'd660);
      check("hsync width pd1", 32'(rise[0] - fall[0]), 32'd96);
      check("hsync width pd2", 32'(rise[1] - fall[1]), 32'd96);
      check("hsync width pd4", 32'(rise[2] - fall[2]), 32'd96);
      check("first video_on pd1", 32'(vo_first[0]), 32'd1);
      check("first video_on pd2", 32'(vo_first[1]), 32'd2);
      check("first video_on pd4", 32'(vo_first[2]), 32'd4);

      // Frame-level behaviour on the narrow instance.
      check("frame_start count", 32'(fs_n), 32'd3);
      check("frame_start first", 32'(fs_cyc[0]), 32'd0);
      check("frame period 1", 32'(fs_cyc[1] - fs_cyc[0]), 32'd12600);
      check("frame period 2", 32'(fs_cyc[2] - fs_cyc[1]), 32'd12600);
      check("vsync low per frame", 32'(win_vs), 32'd48);
      check("video_on per frame", 32'(win_vo), 32'd7680);
      check("hsync low per frame", 32'(win_hs), 32'd2100);

      check("full vectors left", 32'(q_a.size()), 32'd0);
      check("narrow vectors left", 32'(q_s.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
